// File: rtl/key_mode_ctrl.sv
// Front-panel button conditioning and pattern/brightness/freeze control.
// Pending selections are committed to the video generator only at frame boundaries.
module key_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned NUM_PATTERNS    = 8,
    parameter bit          BTN_ACTIVE      = 1'b1,
    parameter bit          VSYNC_ACTIVE    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       B2,
    input  logic       B3,
    input  logic       B4,
    input  logic       B5,
    input  logic       v_sync,
    output logic [2:0] pattern_sel,
    output logic [1:0] brightness,
    output logic       freeze,
    output logic       frame_update,
    output logic [4:0] led
);

    localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      PatMax = 3'(NUM_PATTERNS - 1);

    typedef enum logic [0:0] {StLive, StFrozen} mode_e;

    // ------------------------------------------------------------------
    // Button input stage: normalise to "1 = pressed", synchronise, debounce
    // ------------------------------------------------------------------
    logic [3:0] btn_pressed;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] press_evt;

    assign btn_pressed = {B5, B4, B3, B2} ~^ {4{BTN_ACTIVE}};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_pressed;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            lvl_q, lvl_d;
        logic            lvl_prev_q;
        logic            press_q;

        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (sync2_q[i] != lvl_q) begin
                if (cnt_q == CntMax) begin
                    lvl_d = sync2_q[i];
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q      <= '0;
                lvl_q      <= 1'b0;
                lvl_prev_q <= 1'b0;
                press_q    <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                lvl_q      <= lvl_d;
                lvl_prev_q <= lvl_q;
                press_q    <= lvl_q & ~lvl_prev_q;
            end
        end

        assign press_evt[i] = press_q;
    end

    logic ev_next, ev_prev, ev_bright, ev_freeze;
    assign ev_next   = press_evt[0];
    assign ev_prev   = press_evt[1];
    assign ev_bright = press_evt[2];
    assign ev_freeze = press_evt[3];

    // ------------------------------------------------------------------
    // Frame boundary: first cycle v_sync is active while its registered copy is not
    // ------------------------------------------------------------------
    logic vs_q;
    logic frame_bound;

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q <= ~VSYNC_ACTIVE;
        end else begin
            vs_q <= v_sync;
        end
    end

    assign frame_bound = (v_sync == VSYNC_ACTIVE) && (vs_q != VSYNC_ACTIVE);

    // ------------------------------------------------------------------
    // Freeze mode FSM
    // ------------------------------------------------------------------
    mode_e mode_q, mode_d;
    logic  commit_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= StLive;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (ev_freeze) begin
            case (mode_q)
                StLive:   mode_d = StFrozen;
                StFrozen: mode_d = StLive;
                default:  mode_d = StLive;
            endcase
        end
    end

    always_comb begin
        freeze    = (mode_q == StFrozen);
        commit_en = frame_bound && (mode_q == StLive);
    end

    // ------------------------------------------------------------------
    // Pending selections
    // ------------------------------------------------------------------
    logic [2:0] pat_pend_q, pat_pend_d;
    logic [1:0] bri_pend_q, bri_pend_d;

    always_comb begin
        pat_pend_d = pat_pend_q;
        // Simultaneous next/prev cancel out.
        case ({ev_prev, ev_next})
            2'b01:   pat_pend_d = (pat_pend_q == PatMax) ? 3'd0 : pat_pend_q + 3'd1;
            2'b10:   pat_pend_d = (pat_pend_q == 3'd0) ? PatMax : pat_pend_q - 3'd1;
            default: pat_pend_d = pat_pend_q;
        endcase
        bri_pend_d = ev_bright ? bri_pend_q + 2'd1 : bri_pend_q;
    end

    // ------------------------------------------------------------------
    // Committed values and registered outputs
    // ------------------------------------------------------------------
    logic [2:0] sel_q, sel_d;
    logic [1:0] bri_q, bri_d;
    logic       upd_q, upd_d;
    logic [4:0] led_q, led_d;

    // Commit samples the pending regs before this cycle's events land.
    always_comb begin
        sel_d = sel_q;
        bri_d = bri_q;
        upd_d = 1'b0;
        if (commit_en) begin
            sel_d = pat_pend_q;
            bri_d = bri_pend_q;
            upd_d = (pat_pend_q != sel_q) || (bri_pend_q != bri_q);
        end
        led_d = {(pat_pend_d != sel_d) || (bri_pend_d != bri_d), mode_d == StFrozen, sel_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_pend_q <= 3'd0;
            bri_pend_q <= 2'd3;
            sel_q      <= 3'd0;
            bri_q      <= 2'd3;
            upd_q      <= 1'b0;
            led_q      <= 5'b00000;
        end else begin
            pat_pend_q <= pat_pend_d;
            bri_pend_q <= bri_pend_d;
            sel_q      <= sel_d;
            bri_q      <= bri_d;
            upd_q      <= upd_d;
            led_q      <= led_d;
        end
    end

    assign pattern_sel  = sel_q;
    assign brightness   = bri_q;
    assign frame_update = upd_q;
    assign led          = led_q;

endmodule
